// File: rtl/k_seq_pkg.sv
// k_seq_pkg: shared types, SHA-2 round-constant tables and helpers for the
// K constant sequencer.
// Build option: K_SEQ_SHA512_EN compiles in the 80 x 64-bit SHA-512 table.
package k_seq_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } k_state_e;

    localparam int unsigned ROUND_W = 7;

    localparam logic [31:0] K256 [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

`ifdef K_SEQ_SHA512_EN
    localparam logic [63:0] K512 [80] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };
`endif

    // Number of compression rounds for a given constant width.
    function automatic int unsigned rounds_for(input int unsigned word_w);
        return (word_w == 64) ? 80 : 64;
    endfunction

endpackage

// File: rtl/k_seq_rom_lane.sv
// k_rom_lane: combinational K_t lookup for one lane of the sequencer.
// Build option: K_SEQ_SHA512_EN adds the 64-bit SHA-512 table branch.
// Indices past the end of the table return zero.
module k_rom_lane
    import k_seq_pkg::*;
#(
    parameter int unsigned WORD_W = 32
) (
    input  logic [ROUND_W-1:0] idx,
    output logic [WORD_W-1:0]  k
);

    if (WORD_W == 32) begin : g_sha256
        // SHA-256 table lookup
        always_comb begin
            k = '0;
            if (idx < 7'd64) begin
                k = K256[idx[5:0]];
            end
        end
`ifdef K_SEQ_SHA512_EN
    end else if (WORD_W == 64) begin : g_sha512
        // SHA-512 table lookup
        always_comb begin
            k = '0;
            if (idx < 7'd80) begin
                k = K512[idx];
            end
        end
`endif
    end else begin : g_unsupported
        // Illegal widths are rejected at elaboration in the top level.
        assign k = '0;
    end

endmodule

// File: rtl/k_sequencer.sv
// k_sequencer: streams SHA-2 round constants, LANES per beat, over a
// valid/ready handshake. All outputs come straight from flops; the ROM
// lookup for the next beat is done from round_next and registered on accept.
// Build option: K_SEQ_SHA512_EN enables WORD_W=64 (SHA-512, 80 rounds).
module k_sequencer
    import k_seq_pkg::*;
#(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned LANES  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*WORD_W-1:0]   k_out,
    output logic [ROUND_W-1:0]        round,
    output logic                      last,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned        ROUNDS     = rounds_for(WORD_W);
    localparam logic [ROUND_W-1:0] LANES_R    = ROUND_W'(LANES);
    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(ROUNDS - LANES);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("k_sequencer: LANES must be 1, 2, 4, 8 or 16");
    end
`ifdef K_SEQ_SHA512_EN
    if (WORD_W != 32 && WORD_W != 64) begin : g_bad_width
        $error("k_sequencer: WORD_W must be 32 or 64");
    end
`else
    if (WORD_W != 32) begin : g_bad_width
        $error("k_sequencer: WORD_W must be 32 (SHA-512 table not built)");
    end
`endif

    k_state_e                  state_q, state_d;
    logic [ROUND_W-1:0]        round_q, round_d;
    logic                      last_q, last_d;
    logic                      done_q, done_d;
    logic [LANES*WORD_W-1:0]   k_q, k_d;
    logic [ROUND_W-1:0]        round_next;
    logic                      load;
    logic [LANES*WORD_W-1:0]   rom_vec;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [ROUND_W-1:0] lane_idx;
        assign lane_idx = round_next + ROUND_W'(i);
        k_rom_lane #(.WORD_W(WORD_W)) u_rom (
            .idx (lane_idx),
            .k   (rom_vec[i*WORD_W +: WORD_W])
        );
    end

    // Next-state, next-round and beat-load decisions
    always_comb begin
        state_d    = state_q;
        round_d    = round_q;
        last_d     = last_q;
        done_d     = 1'b0;
        load       = 1'b0;
        round_next = round_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    round_next = '0;
                    round_d    = '0;
                    last_d     = (LAST_ROUND == '0);
                    load       = 1'b1;
                end
            end
            ST_RUN: begin
                // abort wins over an accept in the same cycle
                if (abort) begin
                    state_d = ST_IDLE;
                    last_d  = 1'b0;
                end else if (out_ready) begin
                    if (last_q) begin
                        state_d = ST_IDLE;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        round_next = round_q + LANES_R;
                        round_d    = round_next;
                        last_d     = (round_next == LAST_ROUND);
                        load       = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                last_d  = 1'b0;
            end
        endcase
        k_d = load ? rom_vec : k_q;
    end

    // Output and state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            round_q <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            last_q  <= last_d;
            done_q  <= done_d;
            k_q     <= k_d;
        end
    end

    assign out_valid = (state_q == ST_RUN);
    assign busy      = (state_q != ST_IDLE);
    assign k_out     = k_q;
    assign round     = round_q;
    assign last      = last_q;
    assign done      = done_q;

endmodule

// File: tb/tb_k_sequencer.sv
// tb_k_sequencer: scoreboard bench for k_sequencer (LANES=1 and LANES=4
// SHA-256 instances, plus a SHA-512 LANES=8 instance when K_SEQ_SHA512_EN).
`timescale 1ns/1ps
module tb_k_sequencer;

    localparam logic [31:0] TB_K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef struct {
        logic [127:0] k;
        logic [6:0]   rnd;
        logic         lst;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // ---------------- DUT A: WORD_W=32, LANES=1 ----------------
    logic        start_a, abort_a, ready_a;
    logic        valid_a, last_a, busy_a, done_a;
    logic [31:0] k_a;
    logic [6:0]  round_a;

    k_sequencer #(.WORD_W(32), .LANES(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
        .out_valid(valid_a), .out_ready(ready_a), .k_out(k_a),
        .round(round_a), .last(last_a), .busy(busy_a), .done(done_a)
    );

    // ---------------- DUT B: WORD_W=32, LANES=4 ----------------
    logic         start_b, abort_b, ready_b;
    logic         valid_b, last_b, busy_b, done_b;
    logic [127:0] k_b;
    logic [6:0]   round_b;

    k_sequencer #(.WORD_W(32), .LANES(4)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
        .out_valid(valid_b), .out_ready(ready_b), .k_out(k_b),
        .round(round_b), .last(last_b), .busy(busy_b), .done(done_b)
    );

`ifdef K_SEQ_SHA512_EN
    logic         start_w, abort_w, ready_w;
    logic         valid_w, last_w, busy_w, done_w;
    logic [511:0] k_w;
    logic [6:0]   round_w;

    k_sequencer #(.WORD_W(64), .LANES(8)) dut_w (
        .clk(clk), .rst(rst), .start(start_w), .abort(abort_w),
        .out_valid(valid_w), .out_ready(ready_w), .k_out(k_w),
        .round(round_w), .last(last_w), .busy(busy_w), .done(done_w)
    );
`endif

    exp_t exp_a[$];
    exp_t exp_b[$];
    int   exp_done_a = 0, exp_done_b = 0;
    int   done_cnt_a = 0, done_cnt_b = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- monitor A ----------------
    logic        stall_a = 0, lacc_a = 0;
    logic [31:0] sk_a;
    logic [6:0]  sr_a;
    logic        sl_a;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stall_a = 0;
            lacc_a  = 0;
        end else begin
            if (lacc_a) begin
                chk("done_after_last_a", done_a, 1);
                chk("busy_fall_a", busy_a, 0);
            end else if (done_a) begin
                chk("spurious_done_a", done_a, 0);
            end
            if (done_a) done_cnt_a++;
            if (stall_a) begin
                chk("stall_k_a", k_a, sk_a);
                chk("stall_round_a", round_a, sr_a);
                chk("stall_last_a", last_a, sl_a);
            end
            lacc_a  = 0;
            stall_a = 0;
            if (valid_a && ready_a && !abort_a) begin
                if (exp_a.size() == 0) begin
                    chk("extra_beat_a", round_a, 7'h7f);
                end else begin
                    e = exp_a.pop_front();
                    chk("k_a", k_a, e.k);
                    chk("round_a", round_a, e.rnd);
                    chk("last_a", last_a, e.lst);
                    lacc_a = e.lst;
                end
            end else if (valid_a && !ready_a && !abort_a) begin
                stall_a = 1;
                sk_a = k_a; sr_a = round_a; sl_a = last_a;
            end
        end
    end

    // ---------------- monitor B ----------------
    logic lacc_b = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            lacc_b = 0;
        end else begin
            if (lacc_b) begin
                chk("done_after_last_b", done_b, 1);
                chk("busy_fall_b", busy_b, 0);
            end else if (done_b) begin
                chk("spurious_done_b", done_b, 0);
            end
            if (done_b) done_cnt_b++;
            lacc_b = 0;
            if (valid_b && ready_b && !abort_b) begin
                if (exp_b.size() == 0) begin
                    chk("extra_beat_b", round_b, 7'h7f);
                end else begin
                    e = exp_b.pop_front();
                    chk("k_b", k_b, e.k);
                    chk("round_b", round_b, e.rnd);
                    chk("last_b", last_b, e.lst);
                    lacc_b = e.lst;
                end
            end
        end
    end

    task automatic push_a(input int first, input int count);
        exp_t e;
        for (int i = first; i < first + count; i++) begin
            e.k   = {96'h0, TB_K[i]};
            e.rnd = 7'(i);
            e.lst = (i == 63);
            exp_a.push_back(e);
        end
    endtask

    task automatic wait_done_a(input int budget, input bit rnd, output bit ok);
        ok = 0;
        for (int c = 0; c < budget; c++) begin
            if (rnd) ready_a = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            if (done_a) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic wait_round_a(input logic [6:0] r, input int budget, output bit ok);
        ok = 0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk); #1;
            if (valid_a && round_a == r) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic check_zero_a(input string tag);
        chk({tag, "_valid_a"}, valid_a, 0);
        chk({tag, "_busy_a"},  busy_a, 0);
        chk({tag, "_done_a"},  done_a, 0);
        chk({tag, "_last_a"},  last_a, 0);
        chk({tag, "_round_a"}, round_a, 0);
        chk({tag, "_k_a"},     k_a, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        exp_t e;
        rst = 1; start_a = 0; abort_a = 0; ready_a = 1;
        start_b = 0; abort_b = 0; ready_b = 1;
`ifdef K_SEQ_SHA512_EN
        start_w = 0; abort_w = 0; ready_w = 1;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero_a("reset");
        chk("reset_valid_b", valid_b, 0);
        chk("reset_k_b", k_b, 0);
        @(posedge clk); #1;
        rst = 0;

        // LANES=1 full run, with a start pulse mid-sequence that must be ignored
        push_a(0, 64);
        exp_done_a++;
        start_a = 1;
        @(negedge clk);
        chk("valid_before_start_edge", valid_a, 0);
        @(posedge clk); #1;
        start_a = 0;
        @(negedge clk);
        chk("first_valid_latency", valid_a, 1);
        repeat (10) @(posedge clk);
        #1 start_a = 1;
        @(posedge clk); #1;
        start_a = 0;
        wait_done_a(200, 0, ok);
        chk("t1_done_seen", ok, 1);

        // restart in the done cycle, under random backpressure
        push_a(0, 64);
        exp_done_a++;
        start_a = 1;
        @(posedge clk); #1;
        start_a = 0;
        wait_done_a(1000, 1, ok);
        chk("t3_done_seen", ok, 1);
        ready_a = 1;

        // LANES=4 run; start in the cycle the last beat is accepted is ignored
        for (int i = 0; i < 16; i++) begin
            e.k   = {TB_K[4*i+3], TB_K[4*i+2], TB_K[4*i+1], TB_K[4*i]};
            e.rnd = 7'(4 * i);
            e.lst = (i == 15);
            exp_b.push_back(e);
        end
        exp_done_b++;
        @(posedge clk); #1;
        start_b = 1;
        @(posedge clk); #1;
        start_b = 0;
        ok = 0;
        for (int c = 0; c < 40; c++) begin
            if (valid_b && round_b == 7'd60) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("t2_reached_round60", ok, 1);
        start_b = 1;
        @(posedge clk); #1;
        start_b = 0;
        repeat (4) @(posedge clk);
        #1;
        chk("t2_idle_after_last", busy_b, 0);
        chk("t2_queue_empty", exp_b.size(), 0);

        // abort at round 20 together with an accept
        push_a(0, 20);
        start_a = 1;
        @(posedge clk); #1;
        start_a = 0;
        wait_round_a(7'd20, 100, ok);
        chk("t4_reached_round20", ok, 1);
        abort_a = 1;
        @(posedge clk); #1;
        abort_a = 0;
        @(negedge clk);
        chk("abort_valid", valid_a, 0);
        chk("abort_busy", busy_a, 0);
        chk("abort_done", done_a, 0);
        chk("abort_queue_empty", exp_a.size(), 0);
        @(posedge clk); #1;
        push_a(0, 64);
        exp_done_a++;
        start_a = 1;
        @(posedge clk); #1;
        start_a = 0;
        wait_done_a(200, 0, ok);
        chk("t4_restart_done_seen", ok, 1);

        // synchronous reset mid-sequence
        push_a(0, 64);
        start_a = 1;
        @(posedge clk); #1;
        start_a = 0;
        wait_round_a(7'd5, 100, ok);
        chk("t5_reached_round5", ok, 1);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check_zero_a("midrst");
        exp_a.delete();

`ifdef K_SEQ_SHA512_EN
        begin
            int beats;
            beats = 0;
            @(posedge clk); #1;
            start_w = 1;
            @(posedge clk); #1;
            start_w = 0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (valid_w) begin
                    if (beats == 0) chk("w_beat0_lane0", k_w[63:0], 64'h428a2f98d728ae22);
                    if (beats == 9) begin
                        chk("w_beat9_lane7", k_w[511:448], 64'h6c44198c4a475817);
                        chk("w_beat9_last", last_w, 1);
                    end
                    beats++;
                end
                if (done_w) break;
            end
            chk("w_beat_count", beats, 10);
        end
`endif

        repeat (3) @(posedge clk);
        chk("final_queue_a", exp_a.size(), 0);
        chk("final_queue_b", exp_b.size(), 0);
        chk("done_count_a", done_cnt_a, exp_done_a);
        chk("done_count_b", done_cnt_b, exp_done_b);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
